// File: rtl/gremlin_ctl.sv
// gremlin_ctl: spawns, walks, kills and respawns one gremlin.
// Publishes {dir, x, y, active} for the collision checker.
module gremlin_ctl #(
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 784,
    parameter int unsigned Y_MIN          = 0,
    parameter int unsigned Y_MAX          = 568,
    parameter int unsigned STEP           = 2,
    parameter int unsigned RESPAWN_FRAMES = 60,
    parameter int unsigned TURN_FRAMES    = 30,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        enable,
    input  logic        timeout,
    input  logic        alive_in,
    output logic [23:0] grem_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALIVE = 2'd1;
    localparam logic [1:0] S_DEAD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] YD_STILL = 2'b00;
    localparam logic [1:0] YD_DOWN  = 2'b01;
    localparam logic [1:0] YD_UP    = 2'b10;

    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam int TW = $clog2(TURN_FRAMES + 1);

    localparam logic [CW-1:0] CNT_LOAD  = CW'(RESPAWN_FRAMES - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_FRAMES - 1);

    localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;

    localparam logic [11:0] XMIN12 = 12'(X_MIN);
    localparam logic [11:0] XMAX12 = 12'(X_MAX);
    localparam logic [11:0] YMIN12 = 12'(Y_MIN);
    localparam logic [11:0] YMAX12 = 12'(Y_MAX);
    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMIN11 = 11'(Y_MIN);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic          vsync_q;
    logic          frame_tick;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic          dir_q, dir_d;
    logic          active_q, active_d;
    logic [1:0]    ydir_q, ydir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] turn_q, turn_d;

    logic [11:0] spawn_x12, spawn_y12;
    logic [10:0] spawn_x, spawn_y;
    logic [11:0] x_plus, y_plus;
    logic [10:0] mv_x, mv_y;
    logic        mv_dir;
    logic [1:0]  redraw, ydir_new;
    logic        turn_wrap;

    assign frame_tick = vsync_in & ~vsync_q;

    // Free-running Fibonacci LFSR, taps 16/14/13/11.
    always_comb begin
        lfsr_d = {lfsr_q[14:0],
                  lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Spawn position from the current LFSR value, clamped to the field.
    always_comb begin
        spawn_x12 = XMIN12 + {2'b00, lfsr_q[9:0]};
        spawn_y12 = YMIN12 + {3'b000, lfsr_q[15:7]};
        spawn_x   = (spawn_x12 > XMAX12) ? XMAX11 : spawn_x12[10:0];
        spawn_y   = (spawn_y12 > YMAX12) ? YMAX11 : spawn_y12[10:0];
    end

    // One frame of motion: horizontal bounce, vertical clamp.
    always_comb begin
        x_plus = {1'b0, x_q} + STEP12;
        y_plus = {1'b0, y_q} + STEP12;
        mv_x   = x_q;
        mv_dir = dir_q;
        if (!dir_q) begin
            if (x_plus > XMAX12) begin
                mv_x   = XMAX11;
                mv_dir = 1'b1;
            end else begin
                mv_x = x_plus[10:0];
            end
        end else begin
            if ({1'b0, x_q} < XMIN12 + STEP12) begin
                mv_x   = XMIN11;
                mv_dir = 1'b0;
            end else begin
                mv_x = x_q - STEP11;
            end
        end

        unique case (lfsr_q[2:1])
            2'b01:   redraw = YD_DOWN;
            2'b10:   redraw = YD_UP;
            default: redraw = YD_STILL;
        endcase
        turn_wrap = (turn_q == TURN_LAST);
        ydir_new  = turn_wrap ? redraw : ydir_q;

        mv_y = y_q;
        if (ydir_new == YD_DOWN) begin
            mv_y = (y_plus > YMAX12) ? YMAX11 : y_plus[10:0];
        end else if (ydir_new == YD_UP) begin
            mv_y = ({1'b0, y_q} < YMIN12 + STEP12) ? YMIN11 : (y_q - STEP11);
        end
    end

    // Gremlin life cycle; timeout overrides every state.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        active_d = active_q;
        ydir_d   = ydir_q;
        cnt_d    = cnt_q;
        turn_d   = turn_q;
        if (timeout) begin
            state_d  = S_HALT;
            active_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (frame_tick && enable) begin
                        state_d  = S_ALIVE;
                        active_d = 1'b1;
                        x_d      = spawn_x;
                        y_d      = spawn_y;
                        dir_d    = lfsr_q[0];
                        ydir_d   = YD_STILL;
                        turn_d   = '0;
                    end
                end
                S_ALIVE: begin
                    if (!alive_in) begin
                        state_d  = S_DEAD;
                        active_d = 1'b0;
                        cnt_d    = CNT_LOAD;
                    end else if (frame_tick) begin
                        x_d    = mv_x;
                        y_d    = mv_y;
                        dir_d  = mv_dir;
                        ydir_d = ydir_new;
                        turn_d = turn_wrap ? '0 : turn_q + 1'b1;
                    end
                end
                S_DEAD: begin
                    if (frame_tick) begin
                        if (cnt_q == '0) begin
                            if (enable) begin
                                state_d  = S_ALIVE;
                                active_d = 1'b1;
                                x_d      = spawn_x;
                                y_d      = spawn_y;
                                dir_d    = lfsr_q[0];
                                ydir_d   = YD_STILL;
                                turn_d   = '0;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            lfsr_q   <= SEED_EFF;
            state_q  <= S_IDLE;
            x_q      <= XMIN11;
            y_q      <= YMIN11;
            dir_q    <= 1'b0;
            active_q <= 1'b0;
            ydir_q   <= YD_STILL;
            cnt_q    <= '0;
            turn_q   <= '0;
        end else begin
            vsync_q  <= vsync_in;
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            active_q <= active_d;
            ydir_q   <= ydir_d;
            cnt_q    <= cnt_d;
            turn_q   <= turn_d;
        end
    end

    assign grem_out = {dir_q, x_q, y_q, active_q};

endmodule

// File: tb/tb_gremlin_ctl.sv
// tb_gremlin_ctl: directed checks of spawn, bounce, kill/respawn,
// timeout and simultaneous-event handling.
module tb_gremlin_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        enable = 1'b0;
    logic        timeout = 1'b0;
    logic        alive_in = 1'b1;
    logic [23:0] grem_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;

    gremlin_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .enable   (enable),
        .timeout  (timeout),
        .alive_in (alive_in),
        .grem_out (grem_out)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16/14/13/11, seed ACE1.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else m_lfsr <= {m_lfsr[14:0],
                        m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [23:0] spawn_exp(input logic [15:0] l);
        int sx;
        int sy;
        sx = int'(l[9:0]);
        if (sx > 784) sx = 784;
        sy = int'(l[15:7]);
        if (sy > 568) sy = 568;
        return {l[0], 11'(sx), 11'(sy), 1'b1};
    endfunction

    task automatic tick(output logic [15:0] l);
        vsync_in = 1'b1;
        l = m_lfsr;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vsync_in = 1'b0;
        enable = 1'b0;
        timeout = 1'b0;
        alive_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic search(input int lo, input int hi, output bit ok);
        ok = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 20000 && !ok; i++) begin
            if (int'(m_lfsr[9:0]) >= lo && int'(m_lfsr[9:0]) <= hi) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL search lfsr[9:0] in %0d..%0d not reached", lo, hi);
        end
    endtask

    task automatic test_reset();
        logic [15:0] l;
        do_reset();
        n_cmp++;
        if (grem_out !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", grem_out, 24'h0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(l);
            n_cmp++;
            if (grem_out !== 24'h0) begin
                n_bad++;
                $display("FAIL idle_disabled tick%0d got=%h exp=%h", i, grem_out, 24'h0);
            end
        end
    endtask

    task automatic test_spawn_walk();
        logic [15:0] l;
        logic [23:0] e;
        int ex, ey, ed, eyd, et;
        enable = 1'b1;
        vsync_in = 1'b1;
        l = m_lfsr;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        e = spawn_exp(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL spawn got=%h exp=%h", grem_out, e);
        end
        ex = int'(e[22:12]);
        ey = int'(e[11:1]);
        ed = int'(e[23]);
        eyd = 0;
        et = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 35; i++) begin
            tick(l);
            if (et == 29) begin
                et = 0;
                eyd = (l[2:1] == 2'b01) ? 1 : (l[2:1] == 2'b10) ? -1 : 0;
            end else et++;
            if (ed == 0) begin
                if (ex + 2 > 784) begin ex = 784; ed = 1; end
                else ex = ex + 2;
            end else begin
                if (ex < 2) begin ex = 0; ed = 0; end
                else ex = ex - 2;
            end
            if (eyd == 1) ey = (ey + 2 > 568) ? 568 : ey + 2;
            else if (eyd == -1) ey = (ey < 2) ? 0 : ey - 2;
            e = {ed[0], 11'(ex), 11'(ey), 1'b1};
            n_cmp++;
            if (grem_out !== e) begin
                n_bad++;
                $display("FAIL walk tick%0d got=%h exp=%h", i, grem_out, e);
            end
        end
    endtask

    task automatic test_bounce_right();
        logic [15:0] l;
        logic [23:0] e;
        bit ok;
        int bx[4] = '{782, 784, 784, 782};
        int bd[4] = '{0, 0, 1, 1};
        do_reset();
        search(780, 780, ok);
        vsync_in = 1'b1;
        l = m_lfsr;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        e = {1'b0, 11'd780, 11'(int'(l[15:7])), 1'b1};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL spawn_780 got=%h exp=%h", grem_out, e);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            tick(l);
            e = {bd[i][0], 11'(bx[i]), e[11:1], 1'b1};
            n_cmp++;
            if (grem_out !== e) begin
                n_bad++;
                $display("FAIL bounce_right step%0d got=%h exp=%h", i, grem_out, e);
            end
        end
    endtask

    task automatic test_bounce_left();
        logic [15:0] l;
        logic [23:0] e;
        bit ok;
        int bx[4] = '{1, 0, 2, 4};
        int bd[4] = '{1, 0, 0, 0};
        do_reset();
        search(3, 3, ok);
        vsync_in = 1'b1;
        l = m_lfsr;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        e = {1'b1, 11'd3, 11'(int'(l[15:7])), 1'b1};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL spawn_3 got=%h exp=%h", grem_out, e);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            tick(l);
            e = {bd[i][0], 11'(bx[i]), e[11:1], 1'b1};
            n_cmp++;
            if (grem_out !== e) begin
                n_bad++;
                $display("FAIL bounce_left step%0d got=%h exp=%h", i, grem_out, e);
            end
        end
    endtask

    task automatic test_spawn_clamp();
        logic [15:0] l;
        logic [23:0] e;
        bit ok;
        do_reset();
        search(785, 1023, ok);
        vsync_in = 1'b1;
        l = m_lfsr;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        e = {l[0], 11'd784, 11'(int'(l[15:7])), 1'b1};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL spawn_clamp got=%h exp=%h", grem_out, e);
        end
        @(posedge clk); #1;
        tick(l);
        e = {1'b1, (e[23] ? 11'd782 : 11'd784), e[11:1], 1'b1};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL clamp_move got=%h exp=%h", grem_out, e);
        end
    endtask

    task automatic test_kill_respawn();
        logic [15:0] l;
        logic [23:0] snap;
        logic [23:0] e;
        snap = grem_out;
        alive_in = 1'b0;
        @(posedge clk); #1;
        alive_in = 1'b1;
        e = {snap[23:1], 1'b0};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL kill got=%h exp=%h", grem_out, e);
        end
        repeat (59) tick(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL dead_59 got=%h exp=%h", grem_out, e);
        end
        tick(l);
        e = spawn_exp(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL respawn_60 got=%h exp=%h", grem_out, e);
        end
        // second kill: alive_in held low while dead, enable dropped at tick 60
        snap = grem_out;
        alive_in = 1'b0;
        @(posedge clk); #1;
        repeat (59) tick(l);
        alive_in = 1'b1;
        enable = 1'b0;
        tick(l);
        tick(l);
        e = {snap[23:1], 1'b0};
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL dead_disabled got=%h exp=%h", grem_out, e);
        end
        enable = 1'b1;
        tick(l);
        e = spawn_exp(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL respawn_enable got=%h exp=%h", grem_out, e);
        end
    endtask

    task automatic test_timeout_alive();
        logic [15:0] l;
        logic [23:0] e;
        e = {grem_out[23:1], 1'b0};
        timeout = 1'b1;
        @(posedge clk); #1;
        timeout = 1'b0;
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL timeout_alive got=%h exp=%h", grem_out, e);
        end
        repeat (3) tick(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL halt_hold got=%h exp=%h", grem_out, e);
        end
    endtask

    task automatic test_timeout_dead();
        logic [15:0] l;
        logic [23:0] e;
        do_reset();
        enable = 1'b1;
        tick(l);
        e = {grem_out[23:1], 1'b0};
        alive_in = 1'b0;
        @(posedge clk); #1;
        alive_in = 1'b1;
        repeat (10) tick(l);
        timeout = 1'b1;
        @(posedge clk); #1;
        timeout = 1'b0;
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL timeout_dead got=%h exp=%h", grem_out, e);
        end
        repeat (70) tick(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL halt_no_respawn got=%h exp=%h", grem_out, e);
        end
        do_reset();
        n_cmp++;
        if (grem_out !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_after_halt got=%h exp=%h", grem_out, 24'h0);
        end
        enable = 1'b1;
        tick(l);
        e = spawn_exp(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL spawn_after_reset got=%h exp=%h", grem_out, e);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] l;
        logic [23:0] e;
        // kill coincident with frame tick: no move, DEAD (respawns after 60)
        e = {grem_out[23:1], 1'b0};
        vsync_in = 1'b1;
        alive_in = 1'b0;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        alive_in = 1'b1;
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL kill_with_tick got=%h exp=%h", grem_out, e);
        end
        @(posedge clk); #1;
        repeat (60) tick(l);
        e = spawn_exp(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL kill_tick_respawn got=%h exp=%h", grem_out, e);
        end
        // kill, tick and timeout together: HALT wins
        e = {grem_out[23:1], 1'b0};
        vsync_in = 1'b1;
        alive_in = 1'b0;
        timeout = 1'b1;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        alive_in = 1'b1;
        timeout = 1'b0;
        @(posedge clk); #1;
        repeat (62) tick(l);
        n_cmp++;
        if (grem_out !== e) begin
            n_bad++;
            $display("FAIL halt_over_kill got=%h exp=%h", grem_out, e);
        end
        // timeout from IDLE together with the spawn tick
        do_reset();
        enable = 1'b1;
        vsync_in = 1'b1;
        timeout = 1'b1;
        @(posedge clk); #1;
        vsync_in = 1'b0;
        timeout = 1'b0;
        @(posedge clk); #1;
        repeat (3) tick(l);
        n_cmp++;
        if (grem_out !== 24'h0) begin
            n_bad++;
            $display("FAIL halt_from_idle got=%h exp=%h", grem_out, 24'h0);
        end
    endtask

    initial begin
        test_reset();
        test_spawn_walk();
        test_bounce_right();
        test_bounce_left();
        test_kill_respawn();
        test_timeout_alive();
        test_spawn_clamp();
        test_timeout_dead();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
